pwm_bank_multi: RTL and testbench

- Parametrised multi-channel PWM generator.
- Successor to the single-channel PWM in the onboarding peripheral.
- Driven by a byte-wide register write/read strobe interface, fed by the SPI register decoder.
- Adds channel count, resolution and prescaler generalisation, plus glitch-free shadowed duty updates at period boundaries.

---
 rtl/pwm_bank_multi.sv | 191 +++++++++++++++++++
 tb/tb_pwm_bank_multi.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_bank_multi.sv
// Multi-channel PWM bank behind a byte-wide register interface, with duty shadowing at period wrap.
// Optional centre-aligned counting is enabled by defining PWM_BANK_CENTER_ALIGN_EN.
module pwm_bank_multi #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick
);
    localparam logic [ADDR_W-1:0]    ADDR_CTRL = ADDR_W'(0);
    localparam logic [ADDR_W-1:0]    ADDR_PRE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]    ADDR_CHEN = ADDR_W'(2);
    localparam int unsigned          DUTY_BASE = 3;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    logic                 run;
    logic                 run_nxt;
    logic                 wr_ctrl;
    logic [7:0]           prescale;
    logic [7:0]           pre_cnt;
    logic [NUM_CH-1:0]    ch_en;
    logic [CNT_WIDTH-1:0] pending [NUM_CH];
    logic [CNT_WIDTH-1:0] active  [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 tick;
    logic                 wrap;
    logic [7:0]           rd_mux;
`ifdef PWM_BANK_CENTER_ALIGN_EN
    logic                 mode;
    logic                 mode_act;
    logic                 cnt_down;
    logic                 cnt_down_nxt;
`endif

    always_comb begin
        wr_ctrl = wr_en && (wr_addr == ADDR_CTRL);
        run_nxt = wr_ctrl ? wr_data[0] : run;
        tick    = run && (pre_cnt == prescale);
    end

    // Next counter value and period-boundary detection
`ifdef PWM_BANK_CENTER_ALIGN_EN
    always_comb begin
        cnt_nxt      = cnt + CNT_ONE;
        cnt_down_nxt = cnt_down;
        wrap         = 1'b0;
        if (mode_act) begin
            if (cnt_down) begin
                cnt_nxt = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    cnt_down_nxt = 1'b0;
                    wrap         = tick;
                end
            end else if (cnt == (CNT_MAX - CNT_ONE)) begin
                cnt_down_nxt = 1'b1;
            end
        end else begin
            wrap = tick && (cnt == CNT_MAX);
        end
    end
`else
    always_comb begin
        cnt_nxt = cnt + CNT_ONE;
        wrap    = tick && (cnt == CNT_MAX);
    end
`endif

    // Control and prescale registers
    always_ff @(posedge clk) begin
        if (rst) begin
            run      <= 1'b0;
            prescale <= '0;
            ch_en    <= '0;
`ifdef PWM_BANK_CENTER_ALIGN_EN
            mode     <= 1'b0;
            mode_act <= 1'b0;
`endif
        end else begin
            run <= run_nxt;
            if (wr_en && (wr_addr == ADDR_PRE)) begin
                prescale <= wr_data;
            end
            if (wr_en && (wr_addr == ADDR_CHEN)) begin
                ch_en <= wr_data[NUM_CH-1:0];
            end
`ifdef PWM_BANK_CENTER_ALIGN_EN
            if (wr_ctrl) begin
                mode <= wr_data[1];
            end
            // Mode is sampled only when counting starts
            if (!run && run_nxt) begin
                mode_act <= wr_data[1];
            end
`endif
        end
    end

    // Pending duty written by software
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                pending[i] <= '0;
            end else if (wr_en && (wr_addr == ADDR_W'(DUTY_BASE + 32'(i)))) begin
                pending[i] <= wr_data[CNT_WIDTH-1:0];
            end
        end
    end

    // Active duty follows pending while stopped, otherwise only at wrap
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                active[i] <= '0;
            end else if (!run || wrap) begin
                active[i] <= pending[i];
            end
        end
    end

    // Prescaler and period counter; a RUN clear zeroes them on the same edge
    always_ff @(posedge clk) begin
        if (rst || !run_nxt) begin
            pre_cnt  <= '0;
            cnt      <= '0;
`ifdef PWM_BANK_CENTER_ALIGN_EN
            cnt_down <= 1'b0;
`endif
        end else if (tick) begin
            pre_cnt  <= '0;
            cnt      <= cnt_nxt;
`ifdef PWM_BANK_CENTER_ALIGN_EN
            cnt_down <= cnt_down_nxt;
`endif
        end else if (run) begin
            pre_cnt <= pre_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out     <= '0;
            period_tick <= 1'b0;
        end else begin
            period_tick <= wrap;
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_out[i] <= run && ch_en[i] && (cnt < active[i]);
            end
        end
    end

    // Read decode; unmapped addresses return zero
    always_comb begin
        rd_mux = 8'h00;
        if (rd_addr == ADDR_CTRL) begin
`ifdef PWM_BANK_CENTER_ALIGN_EN
            rd_mux = {6'b0, mode, run};
`else
            rd_mux = {7'b0, run};
`endif
        end else if (rd_addr == ADDR_PRE) begin
            rd_mux = prescale;
        end else if (rd_addr == ADDR_CHEN) begin
            rd_mux = 8'(ch_en);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_addr == ADDR_W'(DUTY_BASE + 32'(i))) begin
                rd_mux = 8'(pending[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else if (rd_en) begin
            rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_pwm_bank_multi.sv
// Directed bench for pwm_bank_multi: register table plus hand-timed PWM sequences.
module tb_pwm_bank_multi;
    localparam int unsigned NUM_CH = 4;

    typedef struct packed {
        logic       is_wr;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

`ifdef PWM_BANK_CENTER_ALIGN_EN
    localparam logic [7:0] CTRL_FE_EXP = 8'h02;
`else
    localparam logic [7:0] CTRL_FE_EXP = 8'h00;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [3:0]        wr_addr = '0;
    logic [7:0]        wr_data = '0;
    logic              rd_en = 1'b0;
    logic [3:0]        rd_addr = '0;
    logic [7:0]        rd_data;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_tick;

    logic              s_wr_en = 1'b0;
    logic [2:0]        s_wr_addr = '0;
    logic [7:0]        s_wr_data = '0;
    logic              s_rd_en = 1'b0;
    logic [2:0]        s_rd_addr = '0;
    logic [7:0]        s_rd_data;
    logic [1:0]        s_pwm;
    logic              s_tick;

    int n_checks = 0;
    int n_pass   = 0;
    int hi [NUM_CH];
    int tk;
    int first_tk;
    int first_hi;
    logic [7:0] v;
    vec_t vt [22];

    always #5 clk = ~clk;

    pwm_bank_multi #(.NUM_CH(4), .CNT_WIDTH(8), .ADDR_W(4)) u_dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .pwm_out(pwm_out), .period_tick(period_tick)
    );

    pwm_bank_multi #(.NUM_CH(2), .CNT_WIDTH(4), .ADDR_W(3)) u_small (
        .clk(clk), .rst(rst),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
        .pwm_out(s_pwm), .period_tick(s_tick)
    );

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        rd_en = 1'b1; rd_addr = a;
        step();
        rd_en = 1'b0;
        d = rd_data;
    endtask

    task automatic s_wr(input logic [2:0] a, input logic [7:0] d);
        s_wr_en = 1'b1; s_wr_addr = a; s_wr_data = d;
        step();
        s_wr_en = 1'b0;
    endtask

    task automatic s_rd(input logic [2:0] a, output logic [7:0] d);
        s_rd_en = 1'b1; s_rd_addr = a;
        step();
        s_rd_en = 1'b0;
        d = s_rd_data;
    endtask

    // Sample n cycles, counting high cycles per channel and period ticks
    task automatic measure(input int n);
        for (int c = 0; c < NUM_CH; c++) hi[c] = 0;
        tk = 0; first_tk = 0; first_hi = 0;
        for (int k = 1; k <= n; k++) begin
            step();
            for (int c = 0; c < NUM_CH; c++) if (pwm_out[c]) hi[c]++;
            if (pwm_out[0] && first_hi == 0) first_hi = k;
            if (period_tick) begin
                tk++;
                if (first_tk == 0) first_tk = k;
            end
        end
    endtask

    initial begin
        int s_hi0;
        int s_hi1;
        int s_tk;

        vt[0]  = '{1'b0, 4'h0, 8'h00, 8'h00};
        vt[1]  = '{1'b0, 4'h1, 8'h00, 8'h00};
        vt[2]  = '{1'b0, 4'h2, 8'h00, 8'h00};
        vt[3]  = '{1'b0, 4'h3, 8'h00, 8'h00};
        vt[4]  = '{1'b0, 4'h4, 8'h00, 8'h00};
        vt[5]  = '{1'b0, 4'h5, 8'h00, 8'h00};
        vt[6]  = '{1'b0, 4'h6, 8'h00, 8'h00};
        vt[7]  = '{1'b1, 4'hF, 8'hAA, 8'h00};
        vt[8]  = '{1'b0, 4'hF, 8'h00, 8'h00};
        vt[9]  = '{1'b1, 4'h0, 8'hFE, 8'h00};
        vt[10] = '{1'b0, 4'h0, 8'h00, CTRL_FE_EXP};
        vt[11] = '{1'b1, 4'h1, 8'h5A, 8'h00};
        vt[12] = '{1'b0, 4'h1, 8'h00, 8'h5A};
        vt[13] = '{1'b1, 4'h2, 8'hFF, 8'h00};
        vt[14] = '{1'b0, 4'h2, 8'h00, 8'h0F};
        vt[15] = '{1'b1, 4'h6, 8'hC3, 8'h00};
        vt[16] = '{1'b0, 4'h6, 8'h00, 8'hC3};
        vt[17] = '{1'b0, 4'h7, 8'h00, 8'h00};
        vt[18] = '{1'b1, 4'h0, 8'h00, 8'h00};
        vt[19] = '{1'b1, 4'h1, 8'h00, 8'h00};
        vt[20] = '{1'b1, 4'h2, 8'h00, 8'h00};
        vt[21] = '{1'b1, 4'h6, 8'h00, 8'h00};

        repeat (2) @(posedge clk);
        #1;
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_tick", int'(period_tick), 0);
        check("rst_rd_data", int'(rd_data), 0);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            if (vt[i].is_wr) wr(vt[i].addr, vt[i].data);
            else begin
                rd(vt[i].addr, v);
                check($sformatf("reg_vec%0d", i), int'(v), int'(vt[i].exp));
            end
        end

        // Edge-aligned, PRESCALE=0, duty 64 on channel 0
        wr(4'h3, 8'd64); wr(4'h2, 8'h01); wr(4'h0, 8'h01);
        measure(256);
        check("d64_hi_p1", hi[0], 64);
        check("d64_ticks_p1", tk, 1);
        check("d64_first_tick", first_tk, 256);
        check("d64_other_ch", hi[1] + hi[2] + hi[3], 0);
        measure(256);
        check("d64_hi_p2", hi[0], 64);

        // PRESCALE=3, duty 0x80 on channel 1
        wr(4'h0, 8'h00); wr(4'h1, 8'd3); wr(4'h4, 8'h80); wr(4'h2, 8'h02); wr(4'h0, 8'h01);
        measure(1024);
        check("pre3_hi_ch1", hi[1], 512);
        check("pre3_hi_ch0", hi[0], 0);
        check("pre3_ticks", tk, 1);
        check("pre3_first_tick", first_tk, 1024);

        // Mid-period duty change and a write coinciding with wrap
        wr(4'h0, 8'h00); wr(4'h1, 8'd0); wr(4'h2, 8'h01); wr(4'h3, 8'd64); wr(4'h0, 8'h01);
        measure(100);
        check("shadow_hi_first", hi[0], 100 < 64 ? 100 : 64);
        wr(4'h3, 8'd200);
        measure(155);
        check("shadow_hi_rest", hi[0], 0);
        check("shadow_tick_pos", first_tk, 155);
        measure(256);
        check("shadow_hi_new", hi[0], 200);
        measure(255);
        check("shadow_hi_pre_wrap", hi[0], 200);
        check("shadow_no_tick", tk, 0);
        wr(4'h3, 8'd10);
        check("wrap_write_tick", int'(period_tick), 1);
        measure(256);
        check("wrap_write_old_duty", hi[0], 200);
        measure(256);
        check("wrap_write_new_duty", hi[0], 10);

        // RUN cleared while high, then restarted
        wr(4'h0, 8'h00); wr(4'h3, 8'd64); wr(4'h0, 8'h01);
        measure(30);
        check("stop_pre_hi", hi[0], 30);
        wr(4'h0, 8'h00);
        step();
        check("stop_pwm_low", int'(pwm_out), 0);
        check("stop_tick_low", int'(period_tick), 0);
        measure(5);
        check("stop_stays_low", hi[0] + tk, 0);
        wr(4'h0, 8'h01);
        measure(256);
        check("restart_hi", hi[0], 64);
        check("restart_first_hi", first_hi, 1);
        check("restart_first_tick", first_tk, 256);

        // Same-cycle read and write returns old value; rd_data holds without rd_en
        wr_en = 1'b1; wr_addr = 4'h4; wr_data = 8'h11; rd_en = 1'b1; rd_addr = 4'h4;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check("rw_same_old", int'(rd_data), 8'h80);
        rd(4'h4, v);
        check("rw_after_new", int'(v), 8'h11);
        wr(4'h4, 8'h22);
        step();
        check("rd_hold", int'(rd_data), 8'h11);
        check("pre_rst_high", int'(pwm_out[0]), 1);

        // Reset while running
        rst = 1'b1;
        step();
        check("mid_rst_pwm", int'(pwm_out), 0);
        check("mid_rst_tick", int'(period_tick), 0);
        check("mid_rst_rd", int'(rd_data), 0);
        rst = 1'b0;
        rd(4'h0, v);
        check("mid_rst_ctrl", int'(v), 0);
        rd(4'h3, v);
        check("mid_rst_duty0", int'(v), 0);
        measure(20);
        check("mid_rst_idle", hi[0] + tk, 0);

        // Narrow instance: duty masking, max duty, zero duty
        s_wr(3'd3, 8'hAB);
        s_rd(3'd3, v);
        check("small_duty_mask", int'(v), 8'h0B);
        s_wr(3'd5, 8'h77);
        s_rd(3'd5, v);
        check("small_unmapped", int'(v), 0);
        s_wr(3'd3, 8'hFF); s_wr(3'd4, 8'h00); s_wr(3'd2, 8'h03); s_wr(3'd0, 8'h01);
        s_hi0 = 0; s_hi1 = 0; s_tk = 0;
        for (int k = 0; k < 32; k++) begin
            step();
            if (s_pwm[0]) s_hi0++;
            if (s_pwm[1]) s_hi1++;
            if (s_tick) s_tk++;
        end
        check("small_max_duty", s_hi0, 30);
        check("small_zero_duty", s_hi1, 0);
        check("small_ticks", s_tk, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
